ifetch_responder: RTL and testbench
===================================

// Module: ifetch_responder
// PURPOSE
// Responder end of the core's instruction-fetch request: accepts a bundle fetch (address + doFetch) and
// returns one NFU*32-bit VLIW bundle with a one-cycle doneFetch pulse.
// Fills each bundle from a 32-bit backing-memory port, one word per FU lane.
// Keeps a one-entry bundle buffer so a refetch of the same bundle needs no memory traffic.
// Sits between the core's fetch logic and the instruction memory/bus.
// PARAMETERS
// NFU        2   functional units = 32-bit words per bundle; power of two, >=1
// INSTRUCTIONSIZEBYTES  NFU*4  localparam, bundle bytes; INSTRUCTIONSIZE = INSTRUCTIONSIZEBYTES*8 bits
// PORTS
// clk          in   1                  sole clock, rising edge
// rst          in   1                  asynchronous, active-low reset
// address      in   64                 bundle byte address, sampled at accept
// doFetch      in   1                  fetch request, level; sampled only in IDLE
// instruction  out  INSTRUCTIONSIZE    bundle; lane i = instruction[32*i+:32] = word at address+4*i
// doneFetch    out  1                  one-cycle pulse: instruction/fetchFault valid
// fetchFault   out  1                  qualified by doneFetch: misaligned address
// invalidate   in   1                  clear bundle buffer (code modified)
// memReq       out  1                  word read request, held until memRvalid
// memAddr      out  64                 word byte address, stable while memReq=1
// memRdata     in   32                 read data, valid with memRvalid
// memRvalid    in   1                  completes the outstanding memReq; ignored when memReq=0
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, beat=0, bufValid=0, memReq=0, memAddr=0, instruction=0,
//   doneFetch=0, fetchFault=0. A reset mid-fill abandons it; a memRvalid arriving afterwards is ignored.
// - FSM states: IDLE, FILL, DONE.
//   - Accept: state=IDLE and doFetch=1 at a clk edge; latch address into reqAddr.
//   - Misaligned (address[log2(INSTRUCTIONSIZEBYTES)-1:0]!=0): ->DONE;
//     fetchFault=1, instruction=0, no memory access.
//   - Hit (bufValid && bufTag==address): ->DONE, instruction=bufData; latency 1 cycle (doneFetch high in
//     the cycle after the accept edge).
//   - Miss: ->FILL, beat=0, memReq=1, memAddr=address.
//   - FILL: on memRvalid, write memRdata into lane beat.
//     - beat<NFU-1: beat++, memAddr+=4 (mod 2^64), memReq stays 1 (back-to-back beats allowed).
//     - beat=NFU-1: memReq=0, write buffer (tag=reqAddr), ->DONE.
//     - Miss latency = 1 + sum of the beat waits; with zero-wait memory, doneFetch comes NFU+1 cycles after
//       the accept edge.
//   - DONE: doneFetch=1, fetchFault valid, for exactly one cycle; ->IDLE.
// - instruction holds its value from DONE until the next DONE; it never changes in any other cycle.
// - Lanes are only partially updated during FILL in an internal register; the output updates in DONE.
// - doFetch still high in the IDLE cycle after DONE = a new request (normally a buffer hit);
//   no edge detection.
// - doFetch and address are don't-care outside IDLE; changes to them during FILL have no effect.
// - invalidate:
//   - clears bufValid next edge, in any state.
//   - if it is asserted at any time during FILL, that fill still completes and is returned, but is not
//     written to the buffer.
//   - invalidate together with a hit-accept in IDLE: treated as a miss.
// - Fault fetches never touch the buffer. Only one memory beat is ever outstanding.
// STRUCTURE
// - vliw_pkg: WORDBYTES=4, bundle-size function of NFU, fetch_state_t enum {IDLE,FILL,DONE}.
// - Sub-module fetch_bundle_buffer: tag/data/valid, write and invalidate ports, combinational hit.
// - Top: FSM, beat counter ($clog2(NFU) bits, min 1), fill assembly register, memory port.
// TESTING
// 1. Reset mid-FILL (rst low while memReq=1) -> all outputs 0 at once, no doneFetch, late memRvalid ignored.
// 2. NFU=2, zero-wait mem: fetch 0x100, mem returns 0xAAAA0001/0xBBBB0002 -> memAddr 0x100,0x104;
//    instruction=0xBBBB0002_AAAA0001; doneFetch 3 cycles after accept.
// 3. Repeat fetch 0x100 -> no memReq, doneFetch 1 cycle after accept, same bundle.
// 4. Fetch 0x104 (misaligned) -> doneFetch with fetchFault=1, instruction=0, memReq never asserted.
// 5. invalidate mid-fill of 0x200, then refetch 0x200 -> first fetch returns data; refetch misses (2 beats).
// 6. Fetch 0xFFFF_FFFF_FFFF_FFF8, NFU=2 -> memAddr ...FFF8 then ...FFFC; 3-wait-cycle mem stretches
//    latency to 9 cycles; doFetch held high -> back-to-back hit.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW instruction-fetch path: word geometry,
// bundle sizing helpers and the fetch FSM state encoding.
package vliw_pkg;

  localparam int WORDBYTES = 4;
  localparam int WORDBITS  = WORDBYTES * 8;
  localparam int ADDRBITS  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Bytes in one bundle: one 32-bit word per functional unit.
  function automatic int bundle_bytes(input int nfu);
    return nfu * WORDBYTES;
  endfunction

  // Width of the lane/beat counter; never narrower than one bit.
  function automatic int beat_width(input int nfu);
    return (nfu > 1) ? $clog2(nfu) : 1;
  endfunction

endpackage

// File: rtl/fetch_bundle_buffer.sv
// One-entry bundle buffer: remembers the last filled bundle and its byte
// address so a refetch of the same bundle can be answered without memory.
// The hit output is purely combinational on the lookup address.
module fetch_bundle_buffer
  import vliw_pkg::*;
#(
  parameter int DATA_W = 64
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [ADDRBITS-1:0] i_wr_tag,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic                i_inval,
  input  logic [ADDRBITS-1:0] i_lookup_addr,
  output logic                o_hit,
  output logic [DATA_W-1:0]   o_data
);

  logic                r_valid;
  logic [ADDRBITS-1:0] r_tag;
  logic [DATA_W-1:0]   r_data;

  // Storage update; invalidate wins over a simultaneous write so modified
  // code can never be served from a stale entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      if (i_wr_en) begin
        r_tag  <= i_wr_tag;
        r_data <= i_wr_data;
      end
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (i_wr_en) begin
        r_valid <= 1'b1;
      end
    end
  end

  // Combinational lookup.
  always_comb begin
    o_hit  = r_valid && (r_tag == i_lookup_addr);
    o_data = r_data;
  end

endmodule

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder. Accepts a bundle fetch, answers from the
// one-entry bundle buffer when possible, otherwise reads NFU words from the
// 32-bit memory port one beat at a time, then pulses doneFetch for one cycle.
// Misaligned bundle addresses are reported through fetchFault without any
// memory access.
//
// Memory handshake: memReq is a request held high with a stable memAddr
// until memRvalid is seen at a rising edge; that edge completes the beat.
// memRvalid is ignored whenever memReq is low, and at most one beat is
// ever outstanding.
module ifetch_responder
  import vliw_pkg::*;
#(
  parameter  int NFU                  = 2,
  localparam int INSTRUCTIONSIZEBYTES = bundle_bytes(NFU),
  localparam int INSTRUCTIONSIZE      = INSTRUCTIONSIZEBYTES * 8
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRBITS-1:0]        address,
  input  logic                       doFetch,
  output logic [INSTRUCTIONSIZE-1:0] instruction,
  output logic                       doneFetch,
  output logic                       fetchFault,
  input  logic                       invalidate,
  output logic                       memReq,
  output logic [ADDRBITS-1:0]        memAddr,
  input  logic [WORDBITS-1:0]        memRdata,
  input  logic                       memRvalid,
  output logic [1:0]                 o_dbg_state
);

  localparam int BEAT_W = beat_width(NFU);
  localparam int OFFS_W = $clog2(INSTRUCTIONSIZEBYTES);

  fetch_state_t               r_state;
  fetch_state_t               w_state_next;
  logic [BEAT_W-1:0]          r_beat;
  logic [ADDRBITS-1:0]        r_req_addr;
  logic [INSTRUCTIONSIZE-1:0] r_fill;
  logic [INSTRUCTIONSIZE-1:0] r_instruction;
  logic                       r_inval_seen;
  logic                       r_fault;
  logic                       r_mem_req;
  logic [ADDRBITS-1:0]        r_mem_addr;

  logic                       w_misaligned;
  logic                       w_buf_hit;
  logic                       w_hit;
  logic                       w_accept;
  logic                       w_last_beat;
  logic                       w_buf_wr;
  logic [INSTRUCTIONSIZE-1:0] w_buf_data;
  logic [INSTRUCTIONSIZE-1:0] w_fill_next;

  fetch_bundle_buffer #(
    .DATA_W (INSTRUCTIONSIZE)
  ) u_buf (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .i_wr_en       (w_buf_wr),
    .i_wr_tag      (r_req_addr),
    .i_wr_data     (w_fill_next),
    .i_inval       (invalidate),
    .i_lookup_addr (address),
    .o_hit         (w_buf_hit),
    .o_data        (w_buf_data)
  );

  // Request classification and fill-assembly helpers.
  always_comb begin
    w_misaligned = |address[OFFS_W-1:0];
    // An invalidate arriving with the request forces a miss.
    w_hit        = w_buf_hit && !invalidate;
    w_accept     = (r_state == IDLE) && doFetch;
    w_last_beat  = (r_state == FILL) && memRvalid && (r_beat == BEAT_W'(NFU - 1));
    // A fill that saw invalidate at any point is returned but not kept.
    w_buf_wr     = w_last_beat && !r_inval_seen && !invalidate;
    w_fill_next  = r_fill;
    for (int i = 0; i < NFU; i++) begin
      if (r_beat == BEAT_W'(i)) begin
        w_fill_next[WORDBITS*i +: WORDBITS] = memRdata;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (doFetch) begin
          if (w_misaligned || w_hit) begin
            w_state_next = DONE;
          end else begin
            w_state_next = FILL;
          end
        end
      end
      FILL: begin
        if (w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs; fetchFault is only meaningful alongside doneFetch.
  always_comb begin
    doneFetch   = (r_state == DONE);
    fetchFault  = (r_state == DONE) && r_fault;
    instruction = r_instruction;
    memReq      = r_mem_req;
    memAddr     = r_mem_addr;
    o_dbg_state = r_state;
  end

  // Request latch, beat sequencing, lane assembly and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat        <= '0;
      r_req_addr    <= '0;
      r_fill        <= '0;
      r_instruction <= '0;
      r_inval_seen  <= 1'b0;
      r_fault       <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr   <= address;
        r_inval_seen <= 1'b0;
        r_fault      <= w_misaligned;
        if (w_misaligned) begin
          r_instruction <= '0;
        end else if (w_hit) begin
          r_instruction <= w_buf_data;
        end else begin
          r_beat     <= '0;
          r_mem_req  <= 1'b1;
          r_mem_addr <= address;
        end
      end else if (r_state == FILL) begin
        if (invalidate) begin
          r_inval_seen <= 1'b1;
        end
        if (memRvalid) begin
          r_fill <= w_fill_next;
          if (w_last_beat) begin
            r_mem_req     <= 1'b0;
            r_instruction <= w_fill_next;
          end else begin
            r_beat     <= r_beat + BEAT_W'(1);
            r_mem_addr <= r_mem_addr + 64'd4;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder (NFU=2): reset checks, a table of
// fetch vectors with hand-computed bundles and latencies, and hand-written
// sequences for reset mid-fill, back-to-back hits and invalidate-at-accept.
module tb_ifetch_responder;

  localparam int NFU = 2;
  localparam int IW  = NFU * 32;

  logic          clk;
  logic          rst;
  logic [63:0]   address;
  logic          doFetch;
  logic [IW-1:0] instruction;
  logic          doneFetch;
  logic          fetchFault;
  logic          invalidate;
  logic          memReq;
  logic [63:0]   memAddr;
  logic [31:0]   memRdata;
  logic          memRvalid;
  logic [1:0]    dbg_state;

  ifetch_responder #(.NFU(NFU)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .doFetch     (doFetch),
    .instruction (instruction),
    .doneFetch   (doneFetch),
    .fetchFault  (fetchFault),
    .invalidate  (invalidate),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memRdata    (memRdata),
    .memRvalid   (memRvalid),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Backing memory contents.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h100) return 32'hAAAA_0001;
    if (a == 64'h104) return 32'hBBBB_0002;
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  // Memory responder: waits mem_wait cycles per beat, then returns data.
  int          mem_wait  = 0;
  int          stray_cnt = 0;
  int          wcnt      = 0;
  logic [63:0] addr_log[$];

  initial begin
    memRvalid = 1'b0;
    memRdata  = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt > 0) begin
        memRvalid = 1'b1;
        memRdata  = 32'hDEAD_BEEF;
        stray_cnt--;
      end else if (memReq) begin
        if (wcnt >= mem_wait) begin
          memRvalid = 1'b1;
          memRdata  = mem_word(memAddr);
          addr_log.push_back(memAddr);
          wcnt = 0;
        end else begin
          memRvalid = 1'b0;
          wcnt++;
        end
      end else begin
        memRvalid = 1'b0;
        wcnt = 0;
      end
    end
  end

  // instruction may only change together with a doneFetch pulse.
  int            stab_err = 0;
  logic [IW-1:0] prev_instr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !doneFetch && instruction !== prev_instr) stab_err++;
      prev_instr = instruction;
    end
  end

  // Driver: one fetch; latency counted in negedges after the accept edge.
  task automatic do_fetch(input logic [63:0] a, input bit inval_mid, input bit inval_acc,
                          output logic [IW-1:0] instr, output bit fault,
                          output int lat, output int mreq_cyc);
    lat = -1; mreq_cyc = 0; instr = '0; fault = 1'b0;
    @(negedge clk);
    address = a; doFetch = 1'b1; invalidate = inval_acc;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (memReq) mreq_cyc++;
      if (doneFetch) begin
        lat = k; instr = instruction; fault = fetchFault;
      end
      if (k == 1) begin
        doFetch = 1'b0;
        address = {$urandom, $urandom};
        invalidate = inval_mid;
      end else begin
        invalidate = 1'b0;
      end
      if (lat > 0) break;
    end
    invalidate = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          wcyc;
    bit          inval_mid;
    logic [63:0] exp_instr;
    bit          exp_fault;
    int          exp_lat;
    int          exp_beats;
    logic [63:0] exp_a0;
    logic [63:0] exp_a1;
  } vec_t;

  vec_t vecs[8];

  logic [IW-1:0] got_instr;
  bit            got_fault;
  int            got_lat;
  int            got_mreq;
  logic [3:0]    done_pat;
  int            bad_cyc;

  initial begin
    vecs[0] = '{64'h100, 0, 1'b0, 64'hBBBB0002_AAAA0001, 1'b0, 3, 2, 64'h100, 64'h104};
    vecs[1] = '{64'h100, 0, 1'b0, 64'hBBBB0002_AAAA0001, 1'b0, 1, 0, 64'h0, 64'h0};
    vecs[2] = '{64'h104, 0, 1'b0, 64'h0,                 1'b1, 1, 0, 64'h0, 64'h0};
    vecs[3] = '{64'h100, 0, 1'b0, 64'hBBBB0002_AAAA0001, 1'b0, 1, 0, 64'h0, 64'h0};
    vecs[4] = '{64'h200, 0, 1'b1, 64'hC1C70204_C1C30200, 1'b0, 3, 2, 64'h200, 64'h204};
    vecs[5] = '{64'h200, 0, 1'b0, 64'hC1C70204_C1C30200, 1'b0, 3, 2, 64'h200, 64'h204};
    vecs[6] = '{64'h200, 0, 1'b0, 64'hC1C70204_C1C30200, 1'b0, 1, 0, 64'h0, 64'h0};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF8, 3, 1'b0, 64'h3C3FFFFC_3C3BFFF8, 1'b0, 9, 2,
                64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC};

    rst = 1'b0; address = '0; doFetch = 1'b0; invalidate = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_instruction", instruction, 64'h0);
    check("reset_doneFetch", {63'h0, doneFetch}, 64'h0);
    check("reset_fetchFault", {63'h0, fetchFault}, 64'h0);
    check("reset_memReq", {63'h0, memReq}, 64'h0);
    check("reset_memAddr", memAddr, 64'h0);
    check("reset_state", {62'h0, dbg_state}, 64'h0);
    rst = 1'b1;

    // Reset in the middle of a fill, then stray memRvalid afterwards.
    mem_wait = 3;
    @(negedge clk);
    address = 64'h300; doFetch = 1'b1;
    @(posedge clk);
    @(negedge clk);
    doFetch = 1'b0;
    @(negedge clk);
    check("midfill_memReq_before_reset", {63'h0, memReq}, 64'h1);
    rst = 1'b0;
    #1;
    check("midfill_memReq", {63'h0, memReq}, 64'h0);
    check("midfill_memAddr", memAddr, 64'h0);
    check("midfill_doneFetch", {63'h0, doneFetch}, 64'h0);
    check("midfill_state", {62'h0, dbg_state}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    stray_cnt = 2;
    bad_cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (doneFetch || memReq) bad_cyc++;
    end
    check("stray_rvalid_ignored", 64'(bad_cyc), 64'h0);

    // Table-driven fetches.
    for (int i = 0; i < 8; i++) begin
      mem_wait = vecs[i].wcyc;
      addr_log.delete();
      do_fetch(vecs[i].addr, vecs[i].inval_mid, 1'b0, got_instr, got_fault, got_lat, got_mreq);
      check($sformatf("v%0d_latency", i), 64'(got_lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_instruction", i), got_instr, vecs[i].exp_instr);
      check($sformatf("v%0d_fault", i), {63'h0, got_fault}, {63'h0, vecs[i].exp_fault});
      check($sformatf("v%0d_beats", i), 64'(addr_log.size()), 64'(vecs[i].exp_beats));
      if (vecs[i].exp_beats == 0) begin
        check($sformatf("v%0d_no_memReq", i), 64'(got_mreq), 64'h0);
      end else begin
        check($sformatf("v%0d_addr0", i), (addr_log.size() > 0) ? addr_log[0] : '1, vecs[i].exp_a0);
        check($sformatf("v%0d_addr1", i), (addr_log.size() > 1) ? addr_log[1] : '1, vecs[i].exp_a1);
      end
    end

    // doFetch held high: hit, IDLE, hit again, IDLE.
    addr_log.delete();
    @(negedge clk);
    address = 64'hFFFF_FFFF_FFFF_FFF8; doFetch = 1'b1;
    got_mreq = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      done_pat[3-k] = doneFetch;
      if (memReq) got_mreq++;
      if (k == 2) begin
        check("b2b_instruction", instruction, 64'h3C3FFFFC_3C3BFFF8);
        doFetch = 1'b0;
      end
    end
    check("b2b_done_pattern", {60'h0, done_pat}, 64'hA);
    check("b2b_no_memReq", 64'(got_mreq + addr_log.size()), 64'h0);

    // invalidate together with a would-be hit: must go to memory.
    mem_wait = 0;
    addr_log.delete();
    do_fetch(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, got_instr, got_fault, got_lat, got_mreq);
    check("invacc_latency", 64'(got_lat), 64'd3);
    check("invacc_beats", 64'(addr_log.size()), 64'd2);
    check("invacc_instruction", got_instr, 64'h3C3FFFFC_3C3BFFF8);
    addr_log.delete();
    do_fetch(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, got_instr, got_fault, got_lat, got_mreq);
    check("invacc_refetch_latency", 64'(got_lat), 64'd1);
    check("invacc_refetch_beats", 64'(addr_log.size()), 64'd0);

    check("instruction_stable_outside_done", 64'(stab_err), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
